// File: rtl/fifo_word_reader.sv
// Read-side engine for the narrow FIFO: pops one entry every IDLE/POP/CAPTURE
// round, packs WORDS entries LSB-first, presents them on a valid/ready stream.
// Optional partial-word flush on idle timeout: define FIFO_WORD_READER_TIMEOUT_EN.

module fifo_word_reader_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else if (wr_en)   q <= din;
  end
endmodule

module fifo_word_reader #(
  parameter int WIDTH   = 1,
  parameter int WORDS   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_rd_en,
  output logic [WIDTH*WORDS-1:0] out_data,
  output logic [5:0]             out_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, POP, CAPTURE, OUT} state_t;

  localparam logic [5:0] WORDS_C = 6'(WORDS);

  generate
    if (WORDS < 2 || WORDS > 32) begin : g_bad_words
      $error("fifo_word_reader: WORDS must be in 2..32");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("fifo_word_reader: TIMEOUT must be in 1..255");
    end
  endgenerate

  state_t                      state;
  logic [5:0]                  fill;
  logic [5:0]                  fill_nxt;
  logic [WORDS-1:0][WIDTH-1:0] slot_q;
  logic [WORDS-1:0]            slot_wr;
  logic                        slot_clr;
  logic                        flush_partial;

  assign fill_nxt = fill + 6'd1;
  assign slot_clr = (state == OUT) && out_ready;
  assign busy     = (state != IDLE) || (fill != 6'd0);
  assign out_data = slot_q;

  // Slots only ever get written once per word and are zeroed on handshake,
  // so unfilled slots of a partial word already read as 0.
  genvar g;
  generate
    for (g = 0; g < WORDS; g++) begin : g_slot
      assign slot_wr[g] = (state == CAPTURE) && (fill == 6'(g));
      fifo_word_reader_slot #(.WIDTH(WIDTH)) u_slot (
        .clk   (clk),
        .reset (reset),
        .clr   (slot_clr),
        .wr_en (slot_wr[g]),
        .din   (fifo_data),
        .q     (slot_q[g])
      );
    end
  endgenerate

`ifdef FIFO_WORD_READER_TIMEOUT_EN
  logic [7:0] idle_cnt;

  assign flush_partial = (fill != 6'd0) && fifo_empty && (idle_cnt == 8'(TIMEOUT - 1));

  // Counts IDLE cycles spent waiting on an empty FIFO with a partial word held.
  always_ff @(posedge clk) begin
    if (reset)                                                   idle_cnt <= 8'd0;
    else if (state == IDLE && fill != 6'd0 && fifo_empty)        idle_cnt <= flush_partial ? 8'd0 : idle_cnt + 8'd1;
    else                                                         idle_cnt <= 8'd0;
  end
`else
  assign flush_partial = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fill       <= 6'd0;
      out_count  <= 6'd0;
      out_valid  <= 1'b0;
      fifo_rd_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
          end else if (flush_partial) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_count <= fill;
          end
        end
        POP: begin
          // FIFO output is registered: data lands during CAPTURE.
          fifo_rd_en <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          fill <= fill_nxt;
          if (fill_nxt == WORDS_C) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_count <= WORDS_C;
          end else begin
            state <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            fill      <= 6'd0;
            out_valid <= 1'b0;
            out_count <= 6'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader with a registered-output FIFO model.
module tb_fifo_word_reader;
  localparam int WIDTH = 1, WORDS = 8, TIMEOUT = 16;

  logic                   clk = 1'b0, reset = 1'b1, out_ready = 1'b0;
  logic                   fifo_empty = 1'b1;
  logic [WIDTH-1:0]       fifo_data = '0;
  logic                   fifo_rd_en, out_valid, busy;
  logic [WIDTH*WORDS-1:0] out_data;
  logic [5:0]             out_count;

  int n_cmp = 0, n_err = 0;

  // FIFO model: mem/wr_ptr written by the stimulus, rd_ptr by the model
  logic [WIDTH-1:0] mem [0:255];
  int   wr_ptr = 0, rd_ptr = 0, nxt;
  logic flush = 1'b0, toggle_en = 1'b0, tog = 1'b0;
  int   pops = 0, underflow = 0, b2b = 0, early = 0;
  logic prev_rd = 1'b0, empty_d = 1'b1;

  fifo_word_reader #(.WIDTH(WIDTH), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb nxt = rd_ptr + ((fifo_rd_en && rd_ptr != wr_ptr) ? 1 : 0);

  always @(posedge clk) begin
    tog     <= ~tog;
    prev_rd <= fifo_rd_en;
    empty_d <= fifo_empty;
    if (fifo_rd_en) pops <= pops + 1;
    if (fifo_rd_en && prev_rd) b2b <= b2b + 1;
    if (fifo_rd_en && empty_d) early <= early + 1;
    if (fifo_rd_en && rd_ptr == wr_ptr) underflow <= underflow + 1;
    if (fifo_rd_en && rd_ptr != wr_ptr) fifo_data <= mem[rd_ptr[7:0]];
    if (flush) begin
      rd_ptr     <= wr_ptr;
      fifo_empty <= 1'b1;
    end else begin
      rd_ptr     <= nxt;
      fifo_empty <= (nxt == wr_ptr) || (toggle_en && tog);
    end
  end

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = b[i];
      wr_ptr++;
    end
  endtask

  // Leaves reset asserted with the FIFO flushed.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b0; toggle_en = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic start();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (out_count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", out_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_word();
    int cyc, p0;
    p0 = pops;
    push_bits(8'h4D, 8);
    start();
    wait_valid(100, cyc);
    n_cmp++; if (cyc != 24) begin n_err++; $display("FAIL full_latency: got %0d want 24", cyc); end
    n_cmp++; if (out_data !== 8'h4D) begin n_err++; $display("FAIL full_data: got %h want 4d", out_data); end
    n_cmp++; if (out_count !== 6'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", out_count); end
    n_cmp++; if (pops - p0 != 8) begin n_err++; $display("FAIL full_pops: got %0d want 8", pops - p0); end
    n_cmp++; if (b2b != 0) begin n_err++; $display("FAIL full_b2b: got %0d want 0", b2b); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    int chg, rds;
    push_bits(8'hA5, 8);
    d0 = out_data; chg = 0; rds = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_data !== d0 || out_valid !== 1'b1 || out_count !== 6'd8) chg++;
      if (fifo_rd_en) rds++;
    end
    n_cmp++; if (chg != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", chg); end
    n_cmp++; if (rds != 0) begin n_err++; $display("FAIL bp_no_pop: got %0d pops want 0", rds); end
    handshake();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (out_count !== 6'd0) begin n_err++; $display("FAIL bp_count_clr: got %0d want 0", out_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL bp_resume: got %b want 1", fifo_rd_en); end
  endtask

  task automatic test_reset_in_out();
    int cyc;
    wait_valid(100, cyc);
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL rst_pre_data: got %h want a5", out_data); end
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", out_data); end
    n_cmp++; if (out_count !== 6'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", out_count); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    push_bits(8'h3C, 8);
    start();
    wait_valid(100, cyc);
    n_cmp++; if (cyc != 24) begin n_err++; $display("FAIL rst_next_latency: got %0d want 24", cyc); end
    n_cmp++; if (out_data !== 8'h3C) begin n_err++; $display("FAIL rst_next_data: got %h want 3c", out_data); end
    handshake();
  endtask

  task automatic test_partial();
    int cyc;
    do_reset();
    push_bits(8'h07, 3);
    start();
`ifdef FIFO_WORD_READER_TIMEOUT_EN
    // last capture ends at edge 9; 16 idle cycles later the word appears
    wait_valid(200, cyc);
    n_cmp++; if (cyc != 25) begin n_err++; $display("FAIL to_latency: got %0d want 25", cyc); end
    n_cmp++; if (out_data !== 8'h07) begin n_err++; $display("FAIL to_data: got %h want 07", out_data); end
    n_cmp++; if (out_count !== 6'd3) begin n_err++; $display("FAIL to_count: got %0d want 3", out_count); end
    handshake();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_busy: got %b want 0", busy); end
`else
    begin
      int seen;
      seen = 0;
      repeat (1000) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL nt_no_valid: got %0d want 0", seen); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL nt_busy: got %b want 1", busy); end
      push_bits(8'h1F, 5);
      wait_valid(100, cyc);
      n_cmp++; if (out_data !== 8'hFF) begin n_err++; $display("FAIL nt_data: got %h want ff", out_data); end
      n_cmp++; if (out_count !== 6'd8) begin n_err++; $display("FAIL nt_count: got %0d want 8", out_count); end
      handshake();
    end
`endif
  endtask

  task automatic test_toggle_empty();
    int cyc, p0, u0, e0;
    do_reset();
    push_bits(8'h96, 8);
    toggle_en = 1'b1;
    p0 = pops; u0 = underflow; e0 = early;
    start();
    wait_valid(500, cyc);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL tog_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 8'h96) begin n_err++; $display("FAIL tog_data: got %h want 96", out_data); end
    n_cmp++; if (out_count !== 6'd8) begin n_err++; $display("FAIL tog_count: got %0d want 8", out_count); end
    n_cmp++; if (pops - p0 != 8) begin n_err++; $display("FAIL tog_pops: got %0d want 8", pops - p0); end
    n_cmp++; if (early - e0 != 0) begin n_err++; $display("FAIL tog_pop_on_empty: got %0d want 0", early - e0); end
    n_cmp++; if (underflow - u0 != 0) begin n_err++; $display("FAIL tog_underflow: got %0d want 0", underflow - u0); end
    toggle_en = 1'b0;
    handshake();
  endtask

  task automatic test_back_to_back();
    int cyc, cnt, p0, u0;
    do_reset();
    push_bits(8'h5A, 8);
    push_bits(8'hC3, 8);
    p0 = pops; u0 = underflow;
    start();
    out_ready = 1'b1;
    wait_valid(100, cyc);
    n_cmp++; if (cyc != 24) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 24", cyc); end
    n_cmp++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL b2b_first_data: got %h want 5a", out_data); end
    @(posedge clk); #1;
    cnt = 1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b want 0", out_valid); end
    while (!out_valid && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    out_ready = 1'b0;
    // rise-to-rise spacing: handshake cycle plus 3 cycles per entry
    n_cmp++; if (cnt != 3 * WORDS + 1) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", cnt, 3 * WORDS + 1); end
    n_cmp++; if (out_data !== 8'hC3) begin n_err++; $display("FAIL b2b_second_data: got %h want c3", out_data); end
    n_cmp++; if (pops - p0 != 16) begin n_err++; $display("FAIL b2b_pops: got %0d want 16", pops - p0); end
    n_cmp++; if (underflow - u0 != 0) begin n_err++; $display("FAIL b2b_underflow: got %0d want 0", underflow - u0); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_backpressure();
    test_reset_in_out();
    test_partial();
    test_toggle_empty();
    test_back_to_back();
    n_cmp++; if (b2b != 0) begin n_err++; $display("FAIL run_b2b: got %0d want 0", b2b); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_word_reader.md
# fifo_word_reader

Read-side engine for the narrow FIFO buffer. Pops entries one at a time, packs WORDS consecutive entries into one output word (first popped entry in the LSBs), and presents that word on a valid/ready stream to downstream logic. A conservative two-cycle pop cadence makes it immune to the FIFO's one-cycle registered `empty`/`data_out` update.

## Interface
- `WIDTH`, 1, width of one FIFO entry; must match the FIFO instance.
- `WORDS`, 8, entries packed per output word (2..32).
- `TIMEOUT`, 16, idle cycles before a partial word is flushed (only with the timeout feature; 1..255).
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid the cycle after a pop.
- `fifo_rd_en`  out  1  pop strobe to the FIFO `read_en`; one-cycle pulse.
- `out_data`  out  WIDTH*WORDS  packed word; entry k at bits [k*WIDTH +: WIDTH].
- `out_count`  out  6  number of valid entries in `out_data` (WORDS for a full word).
- `out_valid`  out  1  word available.
- `out_ready`  in  1  downstream accepts word when `out_valid && out_ready`.
- `busy`  out  1  high whenever state != IDLE or fill count != 0.

## Operation
- States: IDLE, POP, CAPTURE, OUT.
- IDLE: if `fifo_empty==0` -> POP. If the timeout feature fires -> OUT (partial).
- POP: drive `fifo_rd_en=1` for exactly this cycle; -> CAPTURE unconditionally.
- CAPTURE: write `fifo_data` into slot `fill`; `fill <= fill+1`. If new fill == WORDS -> OUT, else -> IDLE.
- OUT: hold `out_valid=1`, with `out_data`/`out_count` stable until handshake. On `out_ready`: clear `fill` and the shift register to 0, drop `out_valid` next cycle, -> IDLE.
- No pops are issued while in OUT; the FIFO absorbs back-pressure.
- `fill` is a 6-bit counter, never exceeds WORDS, no wrap.
- Unused slots of a partial word read as 0.
- `fifo_rd_en` is never asserted in two consecutive cycles, and never while `fifo_empty==1` was sampled in the preceding IDLE cycle.
- Reset (any state, including mid-OUT or mid-CAPTURE): state=IDLE, `fill=0`, `out_data=0`, `out_count=0`, `out_valid=0`, `fifo_rd_en=0`, `busy=0`, timeout counter=0. A word pending in OUT is discarded. A pop issued in the cycle before reset is lost; the FIFO is expected to be reset together with this block.

## Timing
- Pop cadence: at most one entry per 2 cycles (POP, CAPTURE), plus one IDLE cycle between entries: 3 cycles/entry sustained.
- Latency from `fifo_empty` falling (seen in IDLE) to `fifo_rd_en`: 1 cycle.
- Last CAPTURE to `out_valid` high: 1 cycle.
- Full word from a continuously non-empty FIFO: `out_valid` rises 3*WORDS cycles after leaving reset.
- Handshake completes in the cycle `out_ready` is sampled high with `out_valid` high. `out_ready` may be held high permanently. `out_valid` never drops without a handshake except on reset.
- All outputs registered except `busy` (combinational from state/fill).

## Configuration
- `FIFO_WORD_READER_TIMEOUT_EN` defined: an 8-bit idle counter increments each cycle in IDLE with `fill>0` and `fifo_empty==1`, and clears on any pop or when `fill==0`. When it reaches TIMEOUT, the block enters OUT with `out_count=fill` (partial word).
- Not defined: no counter. A partial word waits in IDLE indefinitely; `out_count` always equals WORDS when `out_valid=1`.

## Test plan
- Reset, then WIDTH=1 and WORDS=8 with the FIFO preloaded with bits 1,0,1,1,0,0,1,0 -> `out_data=8'h4D`, `out_count=8`, `out_valid` at cycle 24, exactly 8 `fifo_rd_en` pulses, none back to back.
- `out_ready=0` for 20 cycles after `out_valid` -> word stable, `fifo_rd_en` stays 0; then `out_ready=1` for 1 cycle -> `out_valid=0` next cycle, `fill=0`, pops resume.
- FIFO empty after 3 entries (1,1,1) with timeout enabled and TIMEOUT=16 -> `out_valid` 16 cycles after the idle condition starts, `out_data=8'h07`, `out_count=3`. With timeout disabled -> no `out_valid` for 1000 cycles.
- `reset` asserted while in OUT with `out_data=8'hA5` -> next cycle all outputs 0 and state IDLE. The next full word starts at slot 0.
- `fifo_empty` toggling every cycle -> `fifo_rd_en` only issued from IDLE with `fifo_empty==0`, capture count equals pop count, and the word matches the FIFO order.
- Two back-to-back words with `out_ready` tied high -> second `out_valid` exactly 3*8+1 cycles after the first handshake, and no entries lost or duplicated.
